dual_diagonal_backsub_stream: RTL and testbench
===============================================

# dual_diagonal_backsub_stream

Parametrised, flow-controlled successor to the dual-diagonal back-substitution stage of the QC-LDPC encoder. It computes the running XOR recursion p(k) = p(k-1) ^ lambda(k) over WIDTH-bit (Z-lane) words, starting from a cyclically rotated seed parity. Frame length is programmable per frame, and the block supports valid/ready backpressure, frame-end marking and framing-error detection. It sits between the lambda (H_s·s) accumulator and the parity packer in the encoder datapath.

## Interface
- WIDTH, 8, bits per word (circulant size Z); must be at least 2.
- MAX_ROWS, 1024, maximum block rows per frame; must be at least 1.
- SHIFT, 1, cyclic rotation applied to the seed; 0 ≤ SHIFT < WIDTH.
- i_clock  in  1  single clock; all logic is on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_num_rows  in  $clog2(MAX_ROWS+1)  rows in the next frame; sampled on the seed handshake.
- i_seed_data  in  WIDTH  seed parity word p0.
- i_seed_valid  in  1  seed valid.
- o_seed_ready  out  1  seed ready.
- i_in_data  in  WIDTH  lambda word.
- i_in_valid  in  1  lambda valid.
- i_in_last  in  1  marks the final lambda word of the frame.
- o_in_ready  out  1  lambda ready.
- o_out_data  out  WIDTH  parity word.
- o_out_valid  out  1  parity valid.
- o_out_last  out  1  marks the final parity word of the frame.
- i_out_ready  in  1  downstream ready.
- o_frame_error  out  1  one-cycle pulse on a framing violation.

## Operation
- States:
  - IDLE: accepting a seed.
  - RUN: accepting lambda words.
- IDLE:
  - o_seed_ready = 1 and o_in_ready = 0.
  - On a seed handshake (valid && ready) with i_num_rows in 1..MAX_ROWS:
    - acc <= rot(i_seed_data), where rot[i] = seed[(i + WIDTH − SHIFT) mod WIDTH].
    - Latch i_num_rows into rows_reg, clear row_cnt, go to RUN.
  - On a seed handshake with i_num_rows = 0 or > MAX_ROWS: discard the seed, pulse o_frame_error, stay in IDLE.
- RUN:
  - o_seed_ready = 0.
  - o_in_ready = !o_out_valid || i_out_ready (single output register with pass-through on pop).
- Input handshake in RUN:
  - y = acc ^ i_in_data; acc <= y.
  - Output register loads y; o_out_valid <= 1.
  - row_cnt increments.
- Frame end occurs on the beat where row_cnt == rows_reg−1, or earlier if i_in_last = 1.
  - On that beat: o_out_last <= 1, acc <= 0, go to IDLE.
- Framing error, pulsed in the cycle after the offending beat:
  - i_in_last = 1 before the counted final beat: frame terminates early.
  - Counted final beat without i_in_last: frame still terminates by count.
- Output register:
  - Pops when o_out_valid && i_out_ready.
  - If no new beat loads in the same cycle, o_out_valid <= 0 and o_out_last <= 0.
- While o_out_valid && !i_out_ready, o_out_data and o_out_last hold stable.
- A seed for the next frame may be accepted while the last parity word is still held in the output register.
- Width rules:
  - All XOR is bitwise over WIDTH; there is no carry.
  - row_cnt is $clog2(MAX_ROWS+1) bits and never wraps past rows_reg.

## Timing
- Reset values:
  - state = IDLE; acc, row_cnt, rows_reg = 0.
  - o_out_data = 0, o_out_valid = 0, o_out_last = 0, o_frame_error = 0.
- o_seed_ready and o_in_ready are forced to 0 while i_reset = 1.
- o_seed_ready rises the first cycle after reset deasserts.
- Reset mid-frame: abandon the frame, drop any pending output word, return to IDLE; no error pulse.
- Latency: 1 cycle from input handshake to o_out_valid, with no bubbles.
- Throughput: 1 word/cycle while i_out_ready = 1.
- Seed-to-first-data: the earliest lambda acceptance is the cycle after the seed handshake.
- Ready paths:
  - o_in_ready is combinational on i_out_ready.
  - o_seed_ready depends only on state and reset.
- All other outputs are registered.

## Test plan
- Basic frame. WIDTH=8, SHIFT=1, seed 0x81, num_rows=3, lambdas 0x01/0x02/0x04 with last on the third word, i_out_ready=1. Required: outputs 0x02, 0x00, 0x04; o_out_last only on 0x04; no error.
- Backpressure. Same stimulus, with i_out_ready held 0 for 3 cycles after the first output. Required: 0x02 holds stable, o_in_ready = 0 during the stall, no words lost or duplicated, identical output sequence.
- Back-to-back frames. Seed 0x01 (num_rows=2) lambdas 0xFF/0x0F, then immediately seed 0x80 (num_rows=1) lambda 0x55. Required: outputs 0xFD, 0xF2, then 0x54; one-cycle seed gap; last on 0xF2 and 0x54.
- Framing errors.
  - num_rows=4 with i_in_last on the 2nd word: error pulse, last on the 2nd output, return to IDLE.
  - num_rows=2 with no last: error pulse after the 2nd beat.
  - num_rows=0: seed discarded, error pulse.
- Reset mid-frame. Assert i_reset after 1 of 3 words. Required: o_out_valid = 0 and o_seed_ready = 0 during reset; then IDLE; the next frame computes from a fresh seed.
- Full-length frame. num_rows=MAX_ROWS with random lambdas and random i_out_ready. Required: output matches the reference recursion; last on word MAX_ROWS only.

Source files
------------

// File: rtl/dual_diagonal_backsub_stream.sv
`default_nettype none
// ============================================================================
// Module   : dual_diagonal_backsub_stream
// Purpose  : Flow-controlled dual-diagonal back-substitution stage. Computes
//            p(k) = p(k-1) ^ lambda(k) over WIDTH-bit words, starting from a
//            cyclically rotated seed parity. The frame length is programmable
//            per frame, and the block reports framing errors.
// Ports    : i_clock, i_reset          - clock, synchronous active-high reset
//            i_num_rows                - rows in next frame (seed handshake)
//            i_seed_data/valid, o_seed_ready - seed parity p0 stream
//            i_in_data/valid/last, o_in_ready - lambda stream
//            o_out_data/valid/last, i_out_ready - parity stream
//            o_frame_error             - one-cycle framing violation pulse
// Revision : 1.0 - initial release
// ============================================================================
module dual_diagonal_backsub_stream #(
  parameter int WIDTH    = 8,
  parameter int MAX_ROWS = 1024,
  parameter int SHIFT    = 1
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [$clog2(MAX_ROWS+1)-1:0] i_num_rows,
  input  logic [WIDTH-1:0]              i_seed_data,
  input  logic                          i_seed_valid,
  output logic                          o_seed_ready,
  input  logic [WIDTH-1:0]              i_in_data,
  input  logic                          i_in_valid,
  input  logic                          i_in_last,
  output logic                          o_in_ready,
  output logic [WIDTH-1:0]              o_out_data,
  output logic                          o_out_valid,
  output logic                          o_out_last,
  input  logic                          i_out_ready,
  output logic                          o_frame_error
);

  localparam int CW = $clog2(MAX_ROWS+1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] seed_rot;
  logic [WIDTH-1:0] y;
  logic [CW-1:0]    rows_reg;
  logic [CW-1:0]    row_cnt;
  logic             seed_fire;
  logic             in_fire;
  logic             rows_ok;
  logic             count_final;
  logic             frame_end;
  logic             pop;

  // Seed rotation: bit i takes seed bit (i - SHIFT) mod WIDTH.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rot
      assign seed_rot[gi] = i_seed_data[(gi + WIDTH - SHIFT) % WIDTH];
    end
  endgenerate

  assign seed_fire   = o_seed_ready & i_seed_valid;
  assign in_fire     = o_in_ready & i_in_valid;
  assign pop         = o_out_valid & i_out_ready;
  assign rows_ok     = (i_num_rows != '0) && (i_num_rows <= CW'(MAX_ROWS));
  assign y           = acc ^ i_in_data;
  // rows_reg is at least 1 whenever RUN is active, so the subtraction is safe.
  assign count_final = (row_cnt == (rows_reg - CW'(1)));
  assign frame_end   = in_fire & (count_final | i_in_last);

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (seed_fire && rows_ok) state_next = ST_RUN;
      ST_RUN:  if (frame_end)            state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Ready outputs; the lambda side passes through when the output pops.
  always_comb begin
    o_seed_ready = 1'b0;
    o_in_ready   = 1'b0;
    if (!i_reset) begin
      case (state)
        ST_IDLE: o_seed_ready = 1'b1;
        ST_RUN:  o_in_ready   = !o_out_valid || i_out_ready;
        default: ;
      endcase
    end
  end

  // Datapath: accumulator, row counting, output register, error pulse.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      acc           <= '0;
      rows_reg      <= '0;
      row_cnt       <= '0;
      o_out_data    <= '0;
      o_out_valid   <= 1'b0;
      o_out_last    <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      // Error: bad length on the seed, or last flag disagreeing with the count.
      o_frame_error <= (seed_fire && !rows_ok) ||
                       (in_fire && (i_in_last != count_final));

      if (seed_fire && rows_ok) begin
        acc      <= seed_rot;
        rows_reg <= i_num_rows;
        row_cnt  <= '0;
      end

      if (in_fire) begin
        if (frame_end) begin
          acc     <= '0;
          row_cnt <= '0;
        end else begin
          acc     <= y;
          row_cnt <= row_cnt + CW'(1);
        end
        o_out_data  <= y;
        o_out_valid <= 1'b1;
        o_out_last  <= frame_end;
      end else if (pop) begin
        o_out_valid <= 1'b0;
        o_out_last  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dual_diagonal_backsub_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_diagonal_backsub_stream
// Purpose  : Self-checking bench for dual_diagonal_backsub_stream. Directed
//            scenarios plus randomized frames compared against a behavioural
//            model of the parity recursion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_diagonal_backsub_stream;

  localparam int WIDTH    = 8;
  localparam int MAX_ROWS = 1024;
  localparam int SHIFT    = 1;
  localparam int CW       = $clog2(MAX_ROWS+1);

  logic          clk;
  logic          rst;
  logic [CW-1:0] num_rows;
  logic [7:0]    seed_data;
  logic          seed_valid;
  logic          seed_ready;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic          frame_error;

  int checks = 0;
  int passes = 0;
  int err_cnt = 0;
  int cyc = 0;
  int seed_cyc = 0;
  int word_cyc = 0;
  int rdy_mode = 0;     // 0: always ready, 1: random, 2: manual
  bit man_rdy = 1'b1;

  logic [7:0] obs_d[$];
  bit         obs_l[$];
  logic [7:0] lam_q[$];
  bit         lst_q[$];
  logic [7:0] exp_d[$];
  bit         exp_l[$];

  dual_diagonal_backsub_stream #(
    .WIDTH(WIDTH), .MAX_ROWS(MAX_ROWS), .SHIFT(SHIFT)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_num_rows(num_rows),
    .i_seed_data(seed_data), .i_seed_valid(seed_valid), .o_seed_ready(seed_ready),
    .i_in_data(in_data), .i_in_valid(in_valid), .i_in_last(in_last), .o_in_ready(in_ready),
    .o_out_data(out_data), .o_out_valid(out_valid), .o_out_last(out_last),
    .i_out_ready(out_ready), .o_frame_error(frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready generator, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = man_rdy;
    endcase
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      obs_d.push_back(out_data);
      obs_l.push_back(out_last);
    end
    if (frame_error) err_cnt++;
  end

  // Reference: rotate seed left by SHIFT, then XOR-accumulate each word.
  function automatic logic [7:0] rot_model(input logic [7:0] s);
    int v;
    v = ((int'(s) << SHIFT) | (int'(s) >> (WIDTH - SHIFT))) & 255;
    return v[7:0];
  endfunction

  task automatic build_expected(input logic [7:0] s);
    logic [7:0] p;
    p = rot_model(s);
    exp_d.delete();
    exp_l.delete();
    for (int i = 0; i < lam_q.size(); i++) begin
      p = p ^ lam_q[i];
      exp_d.push_back(p);
      exp_l.push_back(i == lam_q.size() - 1);
    end
  endtask

  task automatic drive_seed(input logic [7:0] s, input int n, output bit ok);
    ok = 1'b0;
    seed_data  = s;
    num_rows   = CW'(n);
    seed_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (seed_ready) begin
        @(posedge clk); #1;
        seed_cyc = cyc;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    seed_valid = 1'b0;
  endtask

  task automatic drive_word(input logic [7:0] d, input bit l, output bit ok);
    ok = 1'b0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        word_cyc = cyc;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_frame(input logic [7:0] s, input int n, output bit ok);
    bit w;
    drive_seed(s, n, ok);
    if (ok) begin
      for (int i = 0; i < lam_q.size(); i++) begin
        drive_word(lam_q[i], lst_q[i], w);
        if (!w) begin ok = 1'b0; break; end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input int n, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 20000; t++) begin
      if (obs_d.size() >= n) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_data !== 8'h00) $display("FAIL reset_data: got %h want 00", out_data); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passes++;
    checks++; if (out_last !== 1'b0) $display("FAIL reset_last: got %b want 0", out_last); else passes++;
    checks++; if (frame_error !== 1'b0) $display("FAIL reset_err: got %b want 0", frame_error); else passes++;
    checks++; if (seed_ready !== 1'b0) $display("FAIL reset_seed_ready: got %b want 0", seed_ready); else passes++;
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", in_ready); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (seed_ready !== 1'b1) $display("FAIL post_reset_seed_ready: got %b want 1", seed_ready); else passes++;
    checks++; if (in_ready !== 1'b0) $display("FAIL post_reset_in_ready: got %b want 0", in_ready); else passes++;
  endtask

  task automatic test_basic;
    bit ok;
    int e0;
    logic [7:0] ed[3] = '{8'h02, 8'h00, 8'h04};
    bit         el[3] = '{1'b0, 1'b0, 1'b1};
    @(posedge clk); #1;
    rdy_mode = 0;
    obs_d.delete(); obs_l.delete();
    e0 = err_cnt;
    lam_q = '{8'h01, 8'h02, 8'h04};
    lst_q = '{1'b0, 1'b0, 1'b1};
    run_frame(8'h81, 3, ok);
    checks++; if (!ok) $display("FAIL basic_handshake: got timeout want accepted"); else passes++;
    wait_out(3, ok);
    checks++; if (obs_d.size() != 3) $display("FAIL basic_count: got %0d want 3", obs_d.size()); else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= obs_d.size() || obs_d[i] !== ed[i] || obs_l[i] !== el[i])
        $display("FAIL basic_word%0d: got %h/%b want %h/%b", i,
                 (i < obs_d.size()) ? obs_d[i] : 8'hxx, (i < obs_l.size()) ? obs_l[i] : 1'b0, ed[i], el[i]);
      else passes++;
    end
    checks++; if (err_cnt != e0) $display("FAIL basic_err: got %0d pulses want 0", err_cnt - e0); else passes++;
  endtask

  task automatic test_backpressure;
    bit ok;
    bit seen;
    logic [7:0] ed[3] = '{8'h02, 8'h00, 8'h04};
    bit         el[3] = '{1'b0, 1'b0, 1'b1};
    @(posedge clk); #1;
    man_rdy  = 1'b0;
    rdy_mode = 2;
    @(posedge clk); #1;
    obs_d.delete(); obs_l.delete();
    lam_q = '{8'h01, 8'h02, 8'h04};
    lst_q = '{1'b0, 1'b0, 1'b1};
    seen = 1'b0;
    fork
      run_frame(8'h81, 3, ok);
      begin
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          if (out_valid) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) $display("FAIL bp_first_valid: got timeout want valid"); else passes++;
        for (int c = 0; c < 3; c++) begin
          if (c > 0) @(negedge clk);
          checks++; if (out_valid !== 1'b1 || out_data !== 8'h02 || out_last !== 1'b0)
            $display("FAIL bp_hold%0d: got %b/%h/%b want 1/02/0", c, out_valid, out_data, out_last);
          else passes++;
          checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready%0d: got %b want 0", c, in_ready); else passes++;
        end
        man_rdy = 1'b1;
      end
    join
    checks++; if (!ok) $display("FAIL bp_handshake: got timeout want accepted"); else passes++;
    wait_out(3, ok);
    checks++; if (obs_d.size() != 3) $display("FAIL bp_count: got %0d want 3", obs_d.size()); else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= obs_d.size() || obs_d[i] !== ed[i] || obs_l[i] !== el[i])
        $display("FAIL bp_word%0d: got %h/%b want %h/%b", i,
                 (i < obs_d.size()) ? obs_d[i] : 8'hxx, (i < obs_l.size()) ? obs_l[i] : 1'b0, ed[i], el[i]);
      else passes++;
    end
    rdy_mode = 0;
  endtask

  task automatic test_back_to_back;
    bit ok1, ok2;
    int last_cyc;
    logic [7:0] ed[3] = '{8'hFD, 8'hF2, 8'h54};
    bit         el[3] = '{1'b0, 1'b1, 1'b1};
    @(posedge clk); #1;
    rdy_mode = 0;
    obs_d.delete(); obs_l.delete();
    lam_q = '{8'hFF, 8'h0F};
    lst_q = '{1'b0, 1'b1};
    run_frame(8'h01, 2, ok1);
    last_cyc = word_cyc;
    lam_q = '{8'h55};
    lst_q = '{1'b1};
    run_frame(8'h80, 1, ok2);
    checks++; if (!(ok1 && ok2)) $display("FAIL b2b_handshake: got timeout want accepted"); else passes++;
    checks++; if (seed_cyc - last_cyc != 1)
      $display("FAIL b2b_seed_gap: got %0d cycles want 1", seed_cyc - last_cyc); else passes++;
    wait_out(3, ok1);
    checks++; if (obs_d.size() != 3) $display("FAIL b2b_count: got %0d want 3", obs_d.size()); else passes++;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= obs_d.size() || obs_d[i] !== ed[i] || obs_l[i] !== el[i])
        $display("FAIL b2b_word%0d: got %h/%b want %h/%b", i,
                 (i < obs_d.size()) ? obs_d[i] : 8'hxx, (i < obs_l.size()) ? obs_l[i] : 1'b0, ed[i], el[i]);
      else passes++;
    end
  endtask

  task automatic test_framing_errors;
    bit ok;
    int e0;
    logic [7:0] ed[2] = '{8'h12, 8'h30};
    for (int sc = 0; sc < 2; sc++) begin
      @(posedge clk); #1;
      obs_d.delete(); obs_l.delete();
      e0 = err_cnt;
      lam_q = '{8'h11, 8'h22};
      lst_q = (sc == 0) ? '{1'b0, 1'b1} : '{1'b0, 1'b0};
      run_frame(8'h81, (sc == 0) ? 4 : 2, ok);
      wait_out(2, ok);
      checks++; if (!ok || obs_d.size() != 2) $display("FAIL ferr%0d_count: got %0d want 2", sc, obs_d.size()); else passes++;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (i >= obs_d.size() || obs_d[i] !== ed[i] || obs_l[i] !== (i == 1))
          $display("FAIL ferr%0d_word%0d: got %h/%b want %h/%b", sc, i,
                   (i < obs_d.size()) ? obs_d[i] : 8'hxx, (i < obs_l.size()) ? obs_l[i] : 1'b0, ed[i], (i == 1));
        else passes++;
      end
      checks++; if (err_cnt - e0 != 1) $display("FAIL ferr%0d_pulse: got %0d want 1", sc, err_cnt - e0); else passes++;
      checks++; if (seed_ready !== 1'b1) $display("FAIL ferr%0d_idle: got %b want 1", sc, seed_ready); else passes++;
    end
    // Out-of-range lengths: seed is consumed, discarded, and flagged.
    for (int sc = 0; sc < 2; sc++) begin
      @(posedge clk); #1;
      obs_d.delete(); obs_l.delete();
      e0 = err_cnt;
      lam_q.delete(); lst_q.delete();
      run_frame(8'h5A, (sc == 0) ? 0 : MAX_ROWS + 1, ok);
      repeat (4) @(negedge clk);
      checks++; if (!ok) $display("FAIL badlen%0d_handshake: got timeout want accepted", sc); else passes++;
      checks++; if (err_cnt - e0 != 1) $display("FAIL badlen%0d_pulse: got %0d want 1", sc, err_cnt - e0); else passes++;
      checks++; if (seed_ready !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL badlen%0d_idle: got %b/%b want 1/0", sc, seed_ready, in_ready); else passes++;
      checks++; if (obs_d.size() != 0) $display("FAIL badlen%0d_outputs: got %0d want 0", sc, obs_d.size()); else passes++;
    end
    @(posedge clk); #1;
    obs_d.delete(); obs_l.delete();
    lam_q = '{8'h00};
    lst_q = '{1'b1};
    run_frame(8'h01, 1, ok);
    wait_out(1, ok);
    checks++; if (obs_d.size() != 1 || obs_d[0] !== 8'h02 || obs_l[0] !== 1'b1)
      $display("FAIL after_badlen: got %h want 02 with last", (obs_d.size() > 0) ? obs_d[0] : 8'hxx); else passes++;
  endtask

  task automatic test_reset_midframe;
    bit ok;
    int e0;
    logic [7:0] ed[3] = '{8'h02, 8'h00, 8'h04};
    @(posedge clk); #1;
    rdy_mode = 0;
    e0 = err_cnt;
    drive_seed(8'h3C, 3, ok);
    if (ok) drive_word(8'hA5, 1'b0, ok);
    checks++; if (!ok) $display("FAIL rst_mid_handshake: got timeout want accepted"); else passes++;
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (seed_ready !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL rst_mid_ready: got %b/%b want 0/0", seed_ready, in_ready); else passes++;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", out_valid); else passes++;
    @(posedge clk); #1;
    rst = 1'b0;
    obs_d.delete(); obs_l.delete();
    @(negedge clk);
    checks++; if (seed_ready !== 1'b1) $display("FAIL rst_mid_idle: got %b want 1", seed_ready); else passes++;
    @(posedge clk); #1;
    lam_q = '{8'h01, 8'h02, 8'h04};
    lst_q = '{1'b0, 1'b0, 1'b1};
    run_frame(8'h81, 3, ok);
    wait_out(3, ok);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= obs_d.size() || obs_d[i] !== ed[i] || obs_l[i] !== (i == 2))
        $display("FAIL rst_mid_word%0d: got %h want %h", i, (i < obs_d.size()) ? obs_d[i] : 8'hxx, ed[i]);
      else passes++;
    end
    checks++; if (err_cnt != e0) $display("FAIL rst_mid_err: got %0d pulses want 0", err_cnt - e0); else passes++;
  endtask

  task automatic test_random_frames;
    bit ok;
    int e0, n, k, kind, bad;
    bit exp_err;
    logic [7:0] s;
    rdy_mode = 1;
    for (int f = 0; f < 30; f++) begin
      @(posedge clk); #1;
      obs_d.delete(); obs_l.delete();
      lam_q.delete(); lst_q.delete();
      n    = $urandom_range(1, 12);
      kind = $urandom_range(0, 2);
      k    = (kind == 1) ? $urandom_range(1, n) : n;
      s    = 8'($urandom);
      for (int i = 0; i < k; i++) begin
        lam_q.push_back(8'($urandom));
        lst_q.push_back((kind != 2) && (i == k - 1));
      end
      // Error whenever the last flag and the row count disagree on the end.
      exp_err = !(lst_q[k-1] && (k == n));
      build_expected(s);
      e0 = err_cnt;
      run_frame(s, n, ok);
      wait_out(k, ok);
      bad = 0;
      if (obs_d.size() != k) bad = 1;
      for (int i = 0; i < k && i < obs_d.size(); i++)
        if (obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i]) bad = 1;
      checks++; if (bad != 0)
        $display("FAIL rand_frame%0d: got %0d words (first %h) want %0d words (first %h)",
                 f, obs_d.size(), (obs_d.size() > 0) ? obs_d[0] : 8'hxx, k, exp_d[0]);
      else passes++;
      checks++; if ((err_cnt - e0) != int'(exp_err))
        $display("FAIL rand_err%0d: got %0d pulses want %0d", f, err_cnt - e0, exp_err); else passes++;
    end
    rdy_mode = 0;
  endtask

  task automatic test_full_length;
    bit ok;
    int e0;
    logic [7:0] s;
    @(posedge clk); #1;
    rdy_mode = 1;
    obs_d.delete(); obs_l.delete();
    lam_q.delete(); lst_q.delete();
    s = 8'($urandom);
    for (int i = 0; i < MAX_ROWS; i++) begin
      lam_q.push_back(8'($urandom));
      lst_q.push_back(i == MAX_ROWS - 1);
    end
    build_expected(s);
    e0 = err_cnt;
    run_frame(s, MAX_ROWS, ok);
    checks++; if (!ok) $display("FAIL full_handshake: got timeout want accepted"); else passes++;
    wait_out(MAX_ROWS, ok);
    checks++; if (obs_d.size() != MAX_ROWS) $display("FAIL full_count: got %0d want %0d", obs_d.size(), MAX_ROWS); else passes++;
    for (int i = 0; i < MAX_ROWS; i++) begin
      checks++;
      if (i >= obs_d.size() || obs_d[i] !== exp_d[i] || obs_l[i] !== exp_l[i])
        $display("FAIL full_word%0d: got %h/%b want %h/%b", i,
                 (i < obs_d.size()) ? obs_d[i] : 8'hxx, (i < obs_l.size()) ? obs_l[i] : 1'b0, exp_d[i], exp_l[i]);
      else passes++;
    end
    checks++; if (err_cnt != e0) $display("FAIL full_err: got %0d pulses want 0", err_cnt - e0); else passes++;
    rdy_mode = 0;
  endtask

  initial begin
    rst        = 1'b1;
    num_rows   = '0;
    seed_data  = '0;
    seed_valid = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    out_ready  = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_framing_errors();
    test_reset_midframe();
    test_random_frames();
    test_full_length();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
